cpe_checker: RTL and testbench

CPE_CHECKER -- requirements
Module: cpe_checker

---
 rtl/cpe_checker.sv | 143 ++++++++++++++
 tb/tb_cpe_checker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cpe_checker.sv
// cpe_checker
//   Serial syndrome checker for a cyclic (CPE) codeword. An accepted codeword
//   is shifted MSB-first through an LFSR that divides by the generator
//   polynomial; the remainder is the syndrome. A nonzero syndrome flags an
//   error. The data field is passed through uncorrected. A 16-bit saturating
//   counter tallies delivered results that carried an error.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   code       input codeword: [NCODE-1:NPAR] data, [NPAR-1:0] parity
//   in_valid   code is valid
//   in_ready   block can accept a codeword (IDLE only)
//   data       extracted data field, uncorrected
//   syndrome   code(x) mod g(x)
//   err        syndrome nonzero
//   out_valid  data/syndrome/err valid (DONE only)
//   out_ready  downstream accepts the result
//   cnt_clr    synchronous clear of err_cnt (wins over increment)
//   err_cnt    saturating count of delivered results with err=1
//
// state | meaning
// IDLE  | waiting for a codeword, in_ready=1
// SHIFT | one codeword bit consumed per cycle, NCODE cycles
// DONE  | result presented, out_valid=1, waiting for out_ready

module cpe_checker #(
    parameter int            NBIT  = 7,
    parameter int            NCODE = 15,
    parameter int            NPAR  = NCODE - NBIT,
    parameter logic [NPAR:0] POLY  = 9'h1D1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCODE-1:0] code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [NBIT-1:0]  data,
    output logic [NPAR-1:0]  syndrome,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [15:0]      err_cnt
);

    localparam int CW = $clog2(NCODE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [NCODE-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [NPAR-1:0]  s;
    logic [NPAR-1:0]  s_next;
    logic [NBIT-1:0]  data_r;
    logic             err_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [15:0]      err_cnt_r;
    logic             hs_err;

    // One LFSR division step: shift the next codeword bit in and subtract
    // g(x) whenever the outgoing x^NPAR term is set.
    always_comb begin
        s_next = {s[NPAR-2:0], shreg[NCODE-1]}
               ^ (s[NPAR-1] ? POLY[NPAR-1:0] : {NPAR{1'b0}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            s           <= '0;
            data_r      <= '0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg      <= code;
                        data_r     <= code[NCODE-1:NPAR];
                        s          <= '0;
                        err_r      <= 1'b0;
                        cnt        <= CW'(NCODE - 1);
                        in_ready_r <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    s     <= s_next;
                    shreg <= {shreg[NCODE-2:0], 1'b0};
                    cnt   <= cnt - 1'b1;
                    // cnt==0 means code[0] is being consumed this cycle
                    if (cnt == '0) begin
                        err_r       <= |s_next;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign hs_err = (state == DONE) && out_ready && err_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r <= '0;
        end else if (cnt_clr) begin
            err_cnt_r <= '0;
        end else if (hs_err && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign data      = data_r;
    assign syndrome  = s;
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_cpe_checker.sv
// Directed testbench for cpe_checker with default parameters.
module tb_cpe_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] code;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  data;
    logic [7:0]  syndrome;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic        cnt_clr;
    logic [15:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpe_checker dut (
        .clk       (clk),
        .rst       (rst),
        .code      (code),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .syndrome  (syndrome),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_clr   (cnt_clr),
        .err_cnt   (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a codeword for one accepting edge, then scramble code while
    // the block works. Returns edges counted from the accepting edge (inclusive)
    // to the edge after which out_valid is seen; bounded at 40.
    task automatic send(input logic [14:0] c, output int lat);
        @(negedge clk);
        code     = c;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        code     = ~c;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Called at a negedge with out_valid=1.
    task automatic handshake(input logic clr);
        out_ready = 1'b1;
        cnt_clr   = clr;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [14:0] c, input logic [6:0] d,
                              input logic [7:0] syn, input logic e, input logic [15:0] cnt_exp);
        int lat;
        send(c, lat);
        chk({tag, "_latency"},  32'(lat),       32'd16);
        chk({tag, "_valid"},    32'(out_valid), 32'd1);
        chk({tag, "_data"},     32'(data),      32'(d));
        chk({tag, "_syndrome"}, 32'(syndrome),  32'(syn));
        chk({tag, "_err"},      32'(err),       32'(e));
        chk({tag, "_in_ready"}, 32'(in_ready),  32'd0);
        handshake(1'b0);
        chk({tag, "_idle_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_err_cnt"},    32'(err_cnt),   32'(cnt_exp));
    endtask

    initial begin
        int  lat;
        logic seen;
        rst       = 1'b0;
        code      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt_clr   = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data",      32'(data),      32'd0);
        chk("rst_syndrome",  32'(syndrome),  32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        rst = 1'b0;

        // Clean and errored words; x^14 mod g(x) = 0xE8.
        check_word("zero",   15'h0000, 7'h00, 8'h00, 1'b0, 16'd0);
        check_word("valid1", 15'h01D1, 7'h01, 8'h00, 1'b0, 16'd0);
        check_word("flip0",  15'h01D0, 7'h01, 8'h01, 1'b1, 16'd1);
        check_word("x8",     15'h0100, 7'h01, 8'hD1, 1'b1, 16'd2);

        // Backpressure: outputs held, new in_valid ignored.
        send(15'h4000, lat);
        chk("stall_latency", 32'(lat), 32'd16);
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            code      = 15'h1234;
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid",    32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready),  32'd0);
            chk("stall_data",     32'(data),      32'h40);
            chk("stall_syndrome", 32'(syndrome),  32'hE8);
            chk("stall_err",      32'(err),       32'd1);
        end
        in_valid = 1'b0;
        handshake(1'b0);
        chk("stall_rel_ready", 32'(in_ready),  32'd1);
        chk("stall_rel_valid", 32'(out_valid), 32'd0);
        chk("stall_err_cnt",   32'(err_cnt),   32'd3);
        @(posedge clk);
        @(negedge clk);
        chk("stall_stay_idle", 32'(in_ready), 32'd1);

        // Reset in the middle of SHIFT.
        code     = 15'h0100;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_syndrome",  32'(syndrome),  32'd0);
        chk("midrst_err_cnt",   32'(err_cnt),   32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("midrst_no_output", 32'(seen),     32'd0);
        chk("midrst_idle",      32'(in_ready), 32'd1);

        // Saturation from a preset near the top.
        force dut.err_cnt_r = 16'hFFFE;
        #1;
        release dut.err_cnt_r;
        check_word("sat1", 15'h01D0, 7'h01, 8'h01, 1'b1, 16'hFFFF);
        check_word("sat2", 15'h0100, 7'h01, 8'hD1, 1'b1, 16'hFFFF);

        // Clear wins over a simultaneous errored handshake.
        send(15'h0100, lat);
        chk("clr_err", 32'(err), 32'd1);
        handshake(1'b1);
        chk("clr_priority", 32'(err_cnt), 32'd0);
        check_word("after_clr", 15'h4000, 7'h40, 8'hE8, 1'b1, 16'd1);
        cnt_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_idle", 32'(err_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
